// File: rtl/ethernet_rx_axil_drain_if.sv
// AXI-Lite bundle between the RX drain master and the MAC slave port.
// Single-beat reads and writes only; prot and strb are fixed by the master.
interface ethernet_rx_axil_drain_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    logic [addr_width_p-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [addr_width_p-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [data_width_p-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/ethernet_rx_axil_drain.sv
// Drains MAC RX frames over AXI-Lite into a 32-bit word stream.
// Define ETHERNET_RX_DRAIN_STATS_EN to build the frame/drop counters.
module ethernet_rx_axil_drain #(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    parameter int base_addr_p       = 0,
    parameter int rx_len_offset_p   = 'h10,
    parameter int rx_ack_offset_p   = 'h14,
    parameter int rx_data_offset_p  = 'h1000,
    parameter int max_frame_bytes_p = 2048
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         irq_i,
    ethernet_rx_axil_drain_if.master     m_axil,
    output logic [axil_data_width_p-1:0] data_o,
    output logic [3:0]                   keep_o,
    output logic                         last_o,
    output logic                         v_o,
    input  logic                         ready_i,
    output logic                         error_o,
    output logic [15:0]                  frames_o,
    output logic [15:0]                  drops_o
);
    localparam int aw_lp = axil_addr_width_p;
    localparam int dw_lp = axil_data_width_p;
    localparam logic [aw_lp-1:0] len_addr_lp =
        aw_lp'(base_addr_p + rx_len_offset_p);
    localparam logic [aw_lp-1:0] ack_addr_lp =
        aw_lp'(base_addr_p + rx_ack_offset_p);
    localparam logic [aw_lp-1:0] data_addr_lp =
        aw_lp'(base_addr_p + rx_data_offset_p);
    localparam logic [12:0] max_lp = 13'(max_frame_bytes_p);

    typedef enum logic [2:0] {
        IDLE, LEN_AR, LEN_R, DATA_AR,
        DATA_R, PUSH, ACK_W, ACK_B
    } state_e;

    state_e             state_q, state_n;
    logic               arvalid_q, arvalid_n;
    logic [aw_lp-1:0]   araddr_q, araddr_n;
    logic               rready_q, rready_n;
    logic               awvalid_q, awvalid_n;
    logic [aw_lp-1:0]   awaddr_q, awaddr_n;
    logic               wvalid_q, wvalid_n;
    logic [dw_lp-1:0]   wdata_q, wdata_n;
    logic               bready_q, bready_n;
    logic               v_q, v_n;
    logic [dw_lp-1:0]   data_q, data_n;
    logic [3:0]         keep_q, keep_n;
    logic               last_q, last_n;
    logic               error_q, error_n;
    logic [10:0]        idx_q, idx_n;
    logic [10:0]        words_q, words_n;
    logic [1:0]         lenmod_q, lenmod_n;

    logic [11:0] rlen;
    logic [12:0] len_sum;
    logic        rresp_bad;
    logic        drop;
    logic        is_last;
    logic [10:0] idx_inc;
    logic [3:0]  tail_keep;

    assign rlen      = m_axil.rdata[11:0];
    assign len_sum   = {1'b0, rlen} + 13'd3;
    assign rresp_bad = m_axil.rresp != 2'b00;
    assign drop      = (rlen == 12'd0)
                    || ({1'b0, rlen} > max_lp)
                    || rresp_bad;
    assign is_last   = idx_q == (words_q - 11'd1);
    assign idx_inc   = idx_q + 11'd1;
    assign tail_keep = (lenmod_q == 2'd1) ? 4'b0001 :
                       (lenmod_q == 2'd2) ? 4'b0011 :
                       (lenmod_q == 2'd3) ? 4'b0111 :
                                            4'b1111;

    always_comb begin
        state_n   = state_q;
        arvalid_n = arvalid_q;
        araddr_n  = araddr_q;
        rready_n  = rready_q;
        awvalid_n = awvalid_q;
        awaddr_n  = awaddr_q;
        wvalid_n  = wvalid_q;
        wdata_n   = wdata_q;
        bready_n  = bready_q;
        v_n       = v_q;
        data_n    = data_q;
        keep_n    = keep_q;
        last_n    = last_q;
        error_n   = error_q;
        idx_n     = idx_q;
        words_n   = words_q;
        lenmod_n  = lenmod_q;
        unique case (state_q)
            IDLE: if (irq_i) begin
                state_n   = LEN_AR;
                arvalid_n = 1'b1;
                araddr_n  = len_addr_lp;
            end
            LEN_AR: if (m_axil.arready) begin
                state_n   = LEN_R;
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
            end
            LEN_R: if (m_axil.rvalid) begin
                rready_n = 1'b0;
                lenmod_n = rlen[1:0];
                if (rresp_bad) error_n = 1'b1;
                if (drop) begin
                    state_n   = ACK_W;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    awaddr_n  = ack_addr_lp;
                    wdata_n   = dw_lp'(1);
                end else begin
                    state_n   = DATA_AR;
                    words_n   = len_sum[12:2];
                    idx_n     = '0;
                    arvalid_n = 1'b1;
                    araddr_n  = data_addr_lp;
                end
            end
            DATA_AR: if (m_axil.arready) begin
                state_n   = DATA_R;
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
            end
            DATA_R: if (m_axil.rvalid) begin
                state_n  = PUSH;
                rready_n = 1'b0;
                data_n   = m_axil.rdata;
                v_n      = 1'b1;
                last_n   = is_last;
                keep_n   = is_last ? tail_keep : 4'hF;
                if (rresp_bad) error_n = 1'b1;
            end
            PUSH: if (ready_i) begin
                v_n = 1'b0;
                if (last_q) begin
                    state_n   = ACK_W;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    awaddr_n  = ack_addr_lp;
                    wdata_n   = dw_lp'(1);
                end else begin
                    state_n   = DATA_AR;
                    idx_n     = idx_inc;
                    arvalid_n = 1'b1;
                    araddr_n  = data_addr_lp
                              + aw_lp'({idx_inc, 2'b00});
                end
            end
            ACK_W: begin
                if (m_axil.awready) awvalid_n = 1'b0;
                if (m_axil.wready)  wvalid_n  = 1'b0;
                if (!awvalid_n && !wvalid_n) begin
                    state_n  = ACK_B;
                    bready_n = 1'b1;
                end
            end
            ACK_B: if (m_axil.bvalid) begin
                state_n  = IDLE;
                bready_n = 1'b0;
                if (m_axil.bresp != 2'b00) error_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            bready_q  <= 1'b0;
            v_q       <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            error_q   <= 1'b0;
            idx_q     <= '0;
            words_q   <= '0;
            lenmod_q  <= '0;
        end else begin
            state_q   <= state_n;
            arvalid_q <= arvalid_n;
            araddr_q  <= araddr_n;
            rready_q  <= rready_n;
            awvalid_q <= awvalid_n;
            awaddr_q  <= awaddr_n;
            wvalid_q  <= wvalid_n;
            wdata_q   <= wdata_n;
            bready_q  <= bready_n;
            v_q       <= v_n;
            data_q    <= data_n;
            keep_q    <= keep_n;
            last_q    <= last_n;
            error_q   <= error_n;
            idx_q     <= idx_n;
            words_q   <= words_n;
            lenmod_q  <= lenmod_n;
        end
    end

    assign m_axil.awaddr  = awaddr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = '1;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = araddr_q;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;

    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;
    assign v_o     = v_q;
    assign error_o = error_q;

`ifdef ETHERNET_RX_DRAIN_STATS_EN
    logic        dropped_q;
    logic [15:0] frames_q;
    logic [15:0] drops_q;

    // Remember the drop decision so ACK_B knows which counter to bump.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dropped_q <= 1'b0;
            frames_q  <= '0;
            drops_q   <= '0;
        end else begin
            if (state_q == LEN_R && m_axil.rvalid)
                dropped_q <= drop;
            if (state_q == ACK_B && m_axil.bvalid) begin
                if (dropped_q) drops_q  <= drops_q + 16'd1;
                else           frames_q <= frames_q + 16'd1;
            end
        end
    end

    assign frames_o = frames_q;
    assign drops_o  = drops_q;
`else
    assign frames_o = '0;
    assign drops_o  = '0;
`endif
endmodule
